contador_sincrono_decrescente_4bits: RTL and testbench

//  Synchronous down counter: the descending counterpart of the team's ascending
//  4-bit counters in the same lab series.

---
 rtl/contador_sincrono_decrescente_4bits.sv | 31 +++
 tb/tb_contador_sincrono_decrescente_4bits.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/contador_sincrono_decrescente_4bits.sv
// contador_sincrono_decrescente_4bits: cascadable synchronous down counter with load and T enable.
// Define SATURATE_DOWN_EN to hold at 0 instead of wrapping to MODULUS-1.
module contador_sincrono_decrescente_4bits #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             T,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] q_q, q_d, under_q;
`ifdef SATURATE_DOWN_EN
    assign under_q = '0;
`else
    assign under_q = TOP;
`endif
    assign q      = q_q;
    assign zero   = (q_q == '0);
    assign borrow = T & zero;
    // Out-of-range presets clamp to the top count
    always_comb q_d = load ? ((d <= TOP) ? d : TOP) : T ? (zero ? under_q : q_q - WIDTH'(1)) : q_q;
    always_ff @(posedge clk)
        if (!clear) q_q <= TOP;
        else        q_q <= q_d;
endmodule

// File: tb/tb_contador_sincrono_decrescente_4bits.sv
// tb_contador_sincrono_decrescente_4bits: scoreboard bench for a MODULUS=16 counter and a
// two-stage MODULUS=10 cascade.
module tb_contador_sincrono_decrescente_4bits;
`ifdef SATURATE_DOWN_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    typedef struct { logic [3:0] q; logic z; logic b; } exp16_t;
    typedef struct { logic [3:0] q1; logic [3:0] q2; logic b1; } exp10_t;

    logic clk = 1'b0;
    logic clear, T, load;
    logic [3:0] d, q;
    logic zero, borrow;
    logic clear10, T10, load10;
    logic [3:0] d10, q1, q2;
    logic zero1, borrow1, zero2, borrow2;

    exp16_t sb16[$];
    exp10_t sb10[$];
    int errors = 0;
    int checks = 0;
    logic [3:0] m, c1, c2;

    always #5 clk = ~clk;

    contador_sincrono_decrescente_4bits #(.WIDTH(4), .MODULUS(16)) dut (
        .clk(clk), .clear(clear), .T(T), .load(load), .d(d),
        .q(q), .zero(zero), .borrow(borrow)
    );
    contador_sincrono_decrescente_4bits #(.WIDTH(4), .MODULUS(10)) st1 (
        .clk(clk), .clear(clear10), .T(T10), .load(load10), .d(d10),
        .q(q1), .zero(zero1), .borrow(borrow1)
    );
    contador_sincrono_decrescente_4bits #(.WIDTH(4), .MODULUS(10)) st2 (
        .clk(clk), .clear(clear10), .T(borrow1), .load(1'b0), .d(4'd0),
        .q(q2), .zero(zero2), .borrow(borrow2)
    );

    task automatic step16(input logic clr, input logic t, input logic ld, input logic [3:0] dv);
        exp16_t e;
        @(negedge clk);
        clear = clr; T = t; load = ld; d = dv;
        if (!clr) m = 4'd15;
        else if (ld) m = dv;
        else if (t) m = (m == 4'd0) ? (SAT ? 4'd0 : 4'd15) : m - 4'd1;
        e.q = m; e.z = (m == 4'd0); e.b = t && (m == 4'd0);
        sb16.push_back(e);
        @(posedge clk);
        #1;
        e = sb16.pop_front();
        checks++;
        if (q !== e.q || zero !== e.z || borrow !== e.b) begin
            errors++;
            $display("FAIL m16 q/zero/borrow got %0d/%b/%b want %0d/%b/%b", q, zero, borrow, e.q, e.z, e.b);
        end
    endtask

    task automatic step10(input logic clr, input logic t, input logic ld, input logic [3:0] dv);
        exp10_t e;
        logic t2;
        @(negedge clk);
        clear10 = clr; T10 = t; load10 = ld; d10 = dv;
        t2 = !ld && t && (c1 == 4'd0);
        if (!clr) begin
            c1 = 4'd9; c2 = 4'd9;
        end else begin
            if (ld) c1 = (dv <= 4'd9) ? dv : 4'd9;
            else if (t) c1 = (c1 == 4'd0) ? (SAT ? 4'd0 : 4'd9) : c1 - 4'd1;
            if (t2) c2 = (c2 == 4'd0) ? (SAT ? 4'd0 : 4'd9) : c2 - 4'd1;
        end
        e.q1 = c1; e.q2 = c2; e.b1 = t && (c1 == 4'd0);
        sb10.push_back(e);
        @(posedge clk);
        #1;
        e = sb10.pop_front();
        checks++;
        if (q1 !== e.q1 || q2 !== e.q2 || borrow1 !== e.b1) begin
            errors++;
            $display("FAIL m10 q1/q2/borrow1 got %0d/%0d/%b want %0d/%0d/%b", q1, q2, borrow1, e.q1, e.q2, e.b1);
        end
    endtask

    task automatic test_reset();
        step16(0, 0, 0, 0);
        step16(0, 1, 1, 4'd3);
        for (int i = 0; i < 3; i++) step16(1, 0, 0, 0);
    endtask

    task automatic test_count();
        for (int i = 0; i < 18; i++) step16(1, 1, 0, 0);
    endtask

    task automatic test_load();
        step16(1, 0, 1, 4'd5);
        step16(1, 1, 1, 4'd5);
        step16(1, 0, 1, 4'd0);
        step16(1, 1, 1, 4'd0);
        step16(1, 1, 1, 4'd15);
    endtask

    task automatic test_clear_override();
        step16(1, 0, 1, 4'd3);
        step16(0, 1, 1, 4'd7);
        step16(1, 1, 0, 0);
        step16(1, 1, 0, 0);
    endtask

    task automatic test_saturate();
        step16(1, 0, 1, 4'd1);
        for (int i = 0; i < 3; i++) step16(1, 1, 0, 0);
        step16(1, 1, 1, 4'd7);
        step16(1, 0, 0, 0);
    endtask

    task automatic test_cascade();
        step10(0, 0, 0, 0);
        step10(1, 0, 1, 4'd12);
        step10(1, 0, 1, 4'd15);
        step10(1, 0, 1, 4'd4);
        step10(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step10(1, 1, 0, 0);
        step10(1, 0, 0, 0);
    endtask

    initial begin
        clear = 1'b0; T = 1'b0; load = 1'b0; d = '0;
        clear10 = 1'b0; T10 = 1'b0; load10 = 1'b0; d10 = '0;
        m = '0; c1 = '0; c2 = '0;
        test_reset();
        test_count();
        test_load();
        test_clear_override();
        test_saturate();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
